// File: rtl/sram_host_controller_if.sv
// Host request/response and SRAM pin bundle for sram_host_controller.
// With SRAM_CTRL_READBACK_VERIFY_EN defined, the bundle also carries verify_err.
interface sram_host_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_clear;
  logic [1:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       wr_done;
  logic [1:0] sram_sel;
  logic       sram_read;
  logic       sram_clear_n;
  logic [7:0] sram_d;
  logic [7:0] sram_q;
`ifdef SRAM_CTRL_READBACK_VERIFY_EN
  logic       verify_err;
`endif

  // Host side; it also models the SRAM, so it supplies sram_q.
  modport master (
`ifdef SRAM_CTRL_READBACK_VERIFY_EN
    input  verify_err,
`endif
    output req_valid, req_write, req_clear, req_addr, req_data, sram_q,
    input  req_ready, rsp_valid, rsp_data, wr_done,
    input  sram_sel, sram_read, sram_clear_n, sram_d
  );

  modport slave (
`ifdef SRAM_CTRL_READBACK_VERIFY_EN
    output verify_err,
`endif
    input  req_valid, req_write, req_clear, req_addr, req_data, sram_q,
    output req_ready, rsp_valid, rsp_data, wr_done,
    output sram_sel, sram_read, sram_clear_n, sram_d
  );
endinterface

// File: rtl/sram_host_controller.sv
// Sequences host write/read/clear requests into timed SRAM pin cycles.
// Optional SRAM_CTRL_READBACK_VERIFY_EN adds a read-back check after every write.
module sram_host_controller #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int READ_WAIT     = 1,
  parameter int CLEAR_CYCLES  = 2
) (
  input logic                  clk,
  input logic                  rst,
  sram_host_controller_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_SETUP  = 3'd1;
  localparam logic [2:0] W_STROBE = 3'd2;
  localparam logic [2:0] W_HOLD   = 3'd3;
  localparam logic [2:0] R_WAIT   = 3'd4;
  localparam logic [2:0] CLR      = 3'd5;

  localparam int CNT_W = 8;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, last;
  logic             done_wr, done_rd;
  logic             verify;

  logic             ready_q;
  logic             read_q;
  logic             clear_n_q;
  logic [1:0]       sel_q;
  logic [7:0]       d_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_valid_q;
  logic             wr_done_q;

  assign accept = bus.req_valid && ready_q;
  assign last   = (cnt == '0);

  // One down-counter serves every timed state; it is reloaded on each transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = last ? cnt : cnt - 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = cnt;
        if (accept) begin
          if (bus.req_clear) begin
            state_nxt = CLR;
            cnt_nxt   = CNT_W'(CLEAR_CYCLES - 1);
          end else if (bus.req_write) begin
            state_nxt = W_SETUP;
            cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
          end else begin
            state_nxt = R_WAIT;
            cnt_nxt   = CNT_W'(READ_WAIT - 1);
          end
        end
      end
      W_SETUP: if (last) begin
        state_nxt = W_STROBE;
        cnt_nxt   = CNT_W'(STROBE_CYCLES - 1);
      end
      W_STROBE: if (last) begin
        state_nxt = W_HOLD;
        cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
      end
      W_HOLD: if (last) begin
`ifdef SRAM_CTRL_READBACK_VERIFY_EN
        state_nxt = R_WAIT;
        cnt_nxt   = CNT_W'(READ_WAIT - 1);
`else
        state_nxt = IDLE;
`endif
      end
      R_WAIT:  if (last) state_nxt = IDLE;
      CLR:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SRAM_CTRL_READBACK_VERIFY_EN
  logic verify_err_q;

  // verify marks the R_WAIT pass that follows a write rather than a host read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verify       <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      if (state == W_HOLD && last)
        verify <= 1'b1;
      else if (state == R_WAIT && last)
        verify <= 1'b0;
      if (verify && state == R_WAIT && last && bus.sram_q != d_q)
        verify_err_q <= 1'b1;
    end
  end

  assign bus.verify_err = verify_err_q;
  assign done_wr = (state == R_WAIT && last && verify) || (state == CLR && last);
`else
  assign verify  = 1'b0;
  assign done_wr = (state == W_HOLD && last) || (state == CLR && last);
`endif

  assign done_rd = (state == R_WAIT) && last && !verify;

  // Pin outputs are decoded from the next state so every one leaves a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ready_q     <= 1'b0;
      read_q      <= 1'b1;
      clear_n_q   <= 1'b0;
      sel_q       <= 2'd0;
      d_q         <= 8'd0;
      rsp_data_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ready_q     <= (state_nxt == IDLE);
      read_q      <= (state_nxt != W_STROBE);
      clear_n_q   <= (state_nxt != CLR);
      rsp_valid_q <= done_rd;
      wr_done_q   <= done_wr;
      if (accept) begin
        sel_q <= bus.req_addr;
        d_q   <= bus.req_data;
      end
      if (done_rd)
        rsp_data_q <= bus.sram_q;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.sram_read    = read_q;
  assign bus.sram_clear_n = clear_n_q;
  assign bus.sram_sel     = sel_q;
  assign bus.sram_d       = d_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.wr_done      = wr_done_q;

endmodule

// File: tb/tb_sram_host_controller.sv
// Bench for sram_host_controller: pin-level SRAM model, transaction-timeline
// reference model checked every cycle, plus directed literal checks.
module tb_sram_host_controller;
  localparam int S  = 1;
  localparam int T  = 2;
  localparam int H  = 1;
  localparam int RW = 1;
  localparam int C  = 2;
`ifdef SRAM_CTRL_READBACK_VERIFY_EN
  localparam int VX = RW;
`else
  localparam int VX = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_host_controller_if bus ();

  sram_host_controller #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(T),
    .HOLD_CYCLES  (H),
    .READ_WAIT    (RW),
    .CLEAR_CYCLES (C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: captures on the falling edge of sram_read, clear is active low.
  logic [7:0] mem [4];
  logic       stuck_en = 1'b0;
  logic [7:0] mask;
  assign mask = stuck_en ? 8'hFE : 8'hFF;
  always @(negedge bus.sram_read or negedge bus.sram_clear_n) begin
    if (!bus.sram_clear_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
    end else begin
      mem[bus.sram_sel] <= bus.sram_d;
    end
  end
  assign bus.sram_q = mem[bus.sram_sel] & mask;

  // Reference: each request occupies a fixed number of cycles, then one idle cycle with its pulse.
  logic       m_live, m_busy, m_ready, m_acc;
  int         m_e, m_occ, m_kind;  // kind: 0 write, 1 read, 2 clear
  logic [1:0] m_sel;
  logic [7:0] m_d, m_rsp;
  logic       m_rspv, m_wrd, m_verr;
  logic [7:0] m_mem [4];
  logic       started = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_live = 0; m_busy = 0; m_ready = 0; m_sel = 0; m_d = 0; m_rsp = 0;
      m_rspv = 0; m_wrd = 0; m_verr = 0; m_e = 0; m_occ = 0; m_kind = 0;
      for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    end else begin
      m_acc  = !m_busy && m_ready && bus.req_valid;
      m_live = 1;
      m_rspv = 0;
      m_wrd  = 0;
      if (m_busy) begin
        if (m_e == m_occ) begin
          m_busy = 0;
          if (m_kind == 1) begin
            m_rspv = 1;
            m_rsp  = m_mem[m_sel] & mask;
          end else begin
            m_wrd = 1;
            if (m_kind == 0 && VX != 0 && ((m_d & mask) != m_d)) m_verr = 1;
          end
        end else begin
          m_e++;
        end
      end else if (m_acc) begin
        m_busy = 1;
        m_e    = 1;
        m_sel  = bus.req_addr;
        m_d    = bus.req_data;
        if (bus.req_clear) begin
          m_kind = 2; m_occ = C;
          for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
        end else if (bus.req_write) begin
          m_kind = 0; m_occ = S + T + H + VX;
          m_mem[bus.req_addr] = bus.req_data;
        end else begin
          m_kind = 1; m_occ = RW;
        end
      end
      m_ready = !m_busy;
    end
  end

  logic exp_read, exp_clr_n;
  assign exp_read  = !(m_busy && m_kind == 0 && m_e > S && m_e <= S + T);
  assign exp_clr_n = m_live && !(m_busy && m_kind == 2);

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready",    32'(bus.req_ready),    32'(m_ready));
      chk("sram_read",    32'(bus.sram_read),    32'(exp_read));
      chk("sram_clear_n", 32'(bus.sram_clear_n), 32'(exp_clr_n));
      chk("sram_sel",     32'(bus.sram_sel),     32'(m_sel));
      chk("sram_d",       32'(bus.sram_d),       32'(m_d));
      chk("rsp_valid",    32'(bus.rsp_valid),    32'(m_rspv));
      chk("rsp_data",     32'(bus.rsp_data),     32'(m_rsp));
      chk("wr_done",      32'(bus.wr_done),      32'(m_wrd));
`ifdef SRAM_CTRL_READBACK_VERIFY_EN
      chk("verify_err",   32'(bus.verify_err),   32'(m_verr));
`endif
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_clear = c;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_clear = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = ~a;
    bus.req_data  = 8'hEE;
  endtask

  task automatic wait_rsp(output logic [7:0] v, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) chk("rsp_timeout", 32'd1, 32'd0);
    v = bus.rsp_data;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.wr_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("done_timeout", 32'd1, 32'd0);
  endtask

  logic [7:0] v;
  int         lat;
  logic [7:0] fill [4];

  initial begin
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_clear = 1'b0;
    bus.req_addr = 2'd0;  bus.req_data = 8'h00;
    rst = 1'b1;
    #1 started = 1'b1;

    @(negedge clk);
    chk("rst_clear_n", 32'(bus.sram_clear_n), 32'd0);
    chk("rst_read",    32'(bus.sram_read),    32'd1);
    chk("rst_ready",   32'(bus.req_ready),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_clear_n", 32'(bus.sram_clear_n), 32'd1);
    chk("rel_ready",   32'(bus.req_ready),    32'd1);

    // Single write: strobe low in cycles 2-3, done pulse after the occupancy.
    send(1'b0, 1'b1, 2'd2, 8'hA5);
    for (int k = 1; k <= 5 + VX; k++) begin
      chk("w_read",  32'(bus.sram_read), (k == 2 || k == 3) ? 32'd0 : 32'd1);
      chk("w_ready", 32'(bus.req_ready), (k == 5 + VX) ? 32'd1 : 32'd0);
      chk("w_done",  32'(bus.wr_done),   (k == 5 + VX) ? 32'd1 : 32'd0);
      chk("w_sel",   32'(bus.sram_sel),  32'd2);
      chk("w_d",     32'(bus.sram_d),    32'hA5);
      if (k < 5 + VX) @(negedge clk);
    end

    // Back-to-back fill, then read-back with no bubbles.
    for (int a = 0; a < 4; a++) send(1'b0, 1'b1, 2'(a), fill[a]);
    send(1'b0, 1'b0, 2'd3, 8'h00);
    wait_rsp(v, lat);
    chk("rd3_data", 32'(v), 32'h44);
    chk("rd3_lat",  32'(lat), 32'(RW));
    send(1'b0, 1'b0, 2'd0, 8'h00);
    wait_rsp(v, lat);
    chk("rd0_data", 32'(v), 32'h11);

    // Clear: clear_n low for two cycles, then done pulse.
    send(1'b1, 1'b0, 2'd1, 8'h77);
    chk("clr_c1", 32'(bus.sram_clear_n), 32'd0);
    @(negedge clk);
    chk("clr_c2", 32'(bus.sram_clear_n), 32'd0);
    @(negedge clk);
    chk("clr_c3", 32'(bus.sram_clear_n), 32'd1);
    chk("clr_done", 32'(bus.wr_done), 32'd1);
    for (int a = 0; a < 4; a++) begin
      send(1'b0, 1'b0, 2'(a), 8'h00);
      wait_rsp(v, lat);
      chk("clr_rd", 32'(v), 32'h00);
    end

    // Reset in the middle of the strobe.
    send(1'b0, 1'b1, 2'd1, 8'h5A);
    @(negedge clk);
    chk("mid_strobe", 32'(bus.sram_read), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_read",  32'(bus.sram_read),    32'd1);
    chk("mid_rst_clr_n", 32'(bus.sram_clear_n), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_no_done", 32'(bus.wr_done), 32'd0);
    end
    chk("mid_ready", 32'(bus.req_ready), 32'd1);
    send(1'b0, 1'b0, 2'd1, 8'h00);
    wait_rsp(v, lat);
    chk("mid_rd", 32'(v), 32'h00);

`ifdef SRAM_CTRL_READBACK_VERIFY_EN
    stuck_en = 1'b1;
    chk("verr_init", 32'(bus.verify_err), 32'd0);
    send(1'b0, 1'b1, 2'd0, 8'h01);
    wait_done();
    chk("verr_set", 32'(bus.verify_err), 32'd1);
    send(1'b0, 1'b1, 2'd0, 8'h02);
    wait_done();
    chk("verr_sticky", 32'(bus.verify_err), 32'd1);
`else
    send(1'b0, 1'b1, 2'd3, 8'h3C);
    wait_done();
    chk("final_done", 32'(bus.wr_done), 32'd1);
`endif

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
